pll_lock_supervisor: RTL

Supervises a PLL from its free-running reference clock. It drives the PLL `rst` input, consumes the PLL's asynchronous `locked` output, and releases a system reset only after lock has been stable for a programmed interval. It re-resets the PLL on lock timeout or on loss of lock, and counts both events. It sits between board reset logic and every PLL wrapper instance, and is clocked by the same 125 MHz `refclk` that feeds the PLL.

---
 rtl/pll_sup_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RESET   = 2'd0,
    WAIT_LOCK   = 2'd1,
    STABLE_WAIT = 2'd2,
    RUN         = 2'd3
  } pll_state_e;

  localparam int EVT_CNT_W = 8;

  // Width of the shared cycle counter: enough to hold the largest interval minus one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for asynchronous status inputs, synchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Holds the PLL in reset, waits for a stable lock, then releases the system reset;
// retries on lock timeout or loss of lock and counts both events.
//
// state       | meaning
// PLL_RESET   | pll_rst asserted for RST_PULSE_CYCLES
// WAIT_LOCK   | pll_rst released, waiting for locked_sync (bounded by timeout)
// STABLE_WAIT | lock seen, must hold for STABLE_CYCLES before release
// RUN         | sys_rst released, ready high
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int STABLE_CYCLES       = 1024
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 relock_req,
  input  logic                 pll_locked,
  output logic                 pll_rst,
  output logic                 sys_rst,
  output logic                 ready,
  output logic [EVT_CNT_W-1:0] timeout_cnt,
  output logic [EVT_CNT_W-1:0] loss_cnt
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [EVT_CNT_W-1:0] EVT_MAX  = '1;

  logic locked_sync;

  pll_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pll_rst_q, pll_rst_d;
  logic                 sys_rst_q, sys_rst_d;
  logic                 ready_q, ready_d;
  logic [EVT_CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [EVT_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                 timeout_evt;
  logic                 loss_evt;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_sync)
  );

  always_comb begin
    state_d     = state_q;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;

    case (state_q)
      PLL_RESET: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_sync) begin
          state_d = STABLE_WAIT;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_evt = 1'b1;
          state_d     = PLL_RESET;
        end
      end
      STABLE_WAIT: begin
        if (!locked_sync) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        if (!locked_sync) begin
          loss_evt = 1'b1;
          state_d  = PLL_RESET;
        end
      end
      default: state_d = PLL_RESET;
    endcase

    // Relock overrides the transition but never suppresses an event that coincides with it.
    if (relock_req) state_d = PLL_RESET;

    // A relock while already in PLL_RESET restarts the pulse; RUN has no interval to time.
    if (state_d != state_q || relock_req || state_q == RUN) cnt_d = '0;
    else cnt_d = cnt_q + CNT_W'(1);

    timeout_cnt_d = timeout_cnt_q;
    if (timeout_evt && timeout_cnt_q != EVT_MAX) timeout_cnt_d = timeout_cnt_q + EVT_CNT_W'(1);

    loss_cnt_d = loss_cnt_q;
    if (loss_evt && loss_cnt_q != EVT_MAX) loss_cnt_d = loss_cnt_q + EVT_CNT_W'(1);

    pll_rst_d = (state_d == PLL_RESET);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= PLL_RESET;
      cnt_q         <= '0;
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
      timeout_cnt_q <= '0;
      loss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_rst_q     <= pll_rst_d;
      sys_rst_q     <= sys_rst_d;
      ready_q       <= ready_d;
      timeout_cnt_q <= timeout_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign timeout_cnt = timeout_cnt_q;
  assign loss_cnt    = loss_cnt_q;

endmodule
